// File: rtl/operand_fetch_unit.sv
// operand_fetch_unit: multi-byte little-endian read sequencer over a pipelined memory port.
// Build macro PAGE_WRAP_EN enables in-page address wrap when a request sets req_page_wrap.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// BUSY  | issuing reads and capturing returns into byte slots
// DONE  | result held on rsp_* until rsp_ready
module operand_fetch_unit #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int MAX_BYTES  = 4,
  parameter int RD_LATENCY = 1,
  localparam int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [LEN_W-1:0]            req_len,
  input  logic                        req_page_wrap,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_rd_en,
  input  logic                        mem_rdy,
  input  logic [DATA_W-1:0]           mem_rd_data,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [MAX_BYTES*DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0]           rsp_next_addr,
  output logic                        rsp_page_cross
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                        state_q, state_d;
  logic [ADDR_W-1:0]             start_q;
  logic [LEN_W-1:0]              len_q;
  logic                          wrap_q;
  logic [LEN_W-1:0]              iss_cnt;
  logic [LEN_W-1:0]              cap_cnt;
  logic [RD_LATENCY-1:0]         rd_pipe;
  logic [MAX_BYTES*DATA_W-1:0]   data_q;
  logic [ADDR_W-1:0]             next_q;
  logic                          cross_q;

  logic                          wrap_in;
  logic [LEN_W-1:0]              len_in;
  logic                          accept;
  logic                          issue_acc;
  logic                          ret_valid;

  // With wrap set, only the low byte of the address advances (page stays fixed).
  function automatic logic [ADDR_W-1:0] addr_add(input logic [ADDR_W-1:0] base,
                                                 input logic [LEN_W-1:0]  off,
                                                 input logic              wrap);
    logic [ADDR_W-1:0] off_ext;
    logic [ADDR_W-1:0] sum;
    off_ext = ADDR_W'(off);
    sum     = base + off_ext;
    if (wrap) sum = {base[ADDR_W-1:8], sum[7:0]};
    return sum;
  endfunction

`ifdef PAGE_WRAP_EN
  assign wrap_in = req_page_wrap;
`else
  logic page_wrap_unused;
  assign page_wrap_unused = req_page_wrap;
  assign wrap_in          = 1'b0;
`endif

  assign len_in    = (req_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : req_len;
  assign accept    = req_valid && req_ready;
  assign issue_acc = mem_rd_en && mem_rdy;
  assign ret_valid = rd_pipe[RD_LATENCY-1];

  assign mem_addr       = addr_add(start_q, iss_cnt, wrap_q);
  assign rsp_data       = data_q;
  assign rsp_next_addr  = next_q;
  assign rsp_page_cross = cross_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_rd_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = BUSY;
      end
      BUSY: begin
        mem_rd_en = (iss_cnt < len_q);
        // cap_cnt is registered, so DONE follows the final capture by one cycle
        if (cap_cnt == len_q) state_d = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      start_q <= '0;
      len_q   <= '0;
      wrap_q  <= 1'b0;
      iss_cnt <= '0;
      cap_cnt <= '0;
      rd_pipe <= '0;
      data_q  <= '0;
      next_q  <= '0;
      cross_q <= 1'b0;
    end else begin
      rd_pipe[0] <= issue_acc;
      for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];

      if (accept) begin
        start_q <= req_addr;
        len_q   <= len_in;
        wrap_q  <= wrap_in;
        iss_cnt <= '0;
        cap_cnt <= '0;
        data_q  <= '0;
        cross_q <= 1'b0;
        next_q  <= addr_add(req_addr, len_in, wrap_in);
      end

      if (issue_acc) begin
        iss_cnt <= iss_cnt + 1'b1;
        if (mem_addr[ADDR_W-1:8] != start_q[ADDR_W-1:8]) cross_q <= 1'b1;
      end

      // Returns arrive in issue order, so the capture counter selects the slot.
      if (ret_valid) begin
        for (int i = 0; i < MAX_BYTES; i++) begin
          if (cap_cnt == LEN_W'(i)) data_q[i*DATA_W +: DATA_W] <= mem_rd_data;
        end
        cap_cnt <= cap_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Bench for operand_fetch_unit: two instances (read latency 1 and 3) driven with identical stimulus,
// each followed by a monitor that pops expected addresses and responses from shared lists.
`timescale 1ns/1ps
module tb_operand_fetch_unit;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic [15:0] req_addr = '0;
  logic [2:0]  req_len = '0;
  logic        req_page_wrap = 1'b0;
  logic        mem_rdy = 1'b1;
  logic        rsp_ready = 1'b1;

  logic        req_ready_a, mem_rd_en_a, rsp_valid_a, rsp_page_cross_a;
  logic [15:0] mem_addr_a, rsp_next_addr_a;
  logic [7:0]  mem_rd_data_a;
  logic [31:0] rsp_data_a;
  logic        req_ready_b, mem_rd_en_b, rsp_valid_b, rsp_page_cross_b;
  logic [15:0] mem_addr_b, rsp_next_addr_b;
  logic [7:0]  mem_rd_data_b;
  logic [31:0] rsp_data_b;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] d;
    logic [15:0] nx;
    logic        cr;
    int          nb;
    int          stalls;
    int          t0;
  } resp_t;

  typedef struct {
    int          ai;
    int          ri;
    bit          vprev;
    logic [31:0] hd;
    logic [15:0] hn;
    logic        hc;
  } mon_t;

  resp_t       rlist[$];
  logic [15:0] alist[$];
  mon_t        ma, mb;

  operand_fetch_unit #(.ADDR_W(16), .DATA_W(8), .MAX_BYTES(4), .RD_LATENCY(LAT_A)) dut_a (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready_a),
    .req_addr(req_addr), .req_len(req_len), .req_page_wrap(req_page_wrap),
    .mem_addr(mem_addr_a), .mem_rd_en(mem_rd_en_a), .mem_rdy(mem_rdy), .mem_rd_data(mem_rd_data_a),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_data(rsp_data_a),
    .rsp_next_addr(rsp_next_addr_a), .rsp_page_cross(rsp_page_cross_a));

  operand_fetch_unit #(.ADDR_W(16), .DATA_W(8), .MAX_BYTES(4), .RD_LATENCY(LAT_B)) dut_b (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready_b),
    .req_addr(req_addr), .req_len(req_len), .req_page_wrap(req_page_wrap),
    .mem_addr(mem_addr_b), .mem_rd_en(mem_rd_en_b), .mem_rdy(mem_rdy), .mem_rd_data(mem_rd_data_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_data(rsp_data_b),
    .rsp_next_addr(rsp_next_addr_b), .rsp_page_cross(rsp_page_cross_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] memf(input logic [15:0] a);
    if (a == 16'hFFFC) return 8'h34;
    if (a == 16'hFFFD) return 8'h12;
    return (a[7:0] + 8'h10) ^ a[15:8];
  endfunction

  // Pipelined memory models; 8'hEE marks a cycle with no valid return.
  logic [15:0] pa_a [LAT_A];
  logic        pv_a [LAT_A];
  logic [15:0] pa_b [LAT_B];
  logic        pv_b [LAT_B];

  always @(posedge clk) begin
    pv_a[0] <= mem_rd_en_a && mem_rdy;
    pa_a[0] <= mem_addr_a;
    for (int i = 1; i < LAT_A; i++) begin
      pv_a[i] <= pv_a[i-1];
      pa_a[i] <= pa_a[i-1];
    end
    pv_b[0] <= mem_rd_en_b && mem_rdy;
    pa_b[0] <= mem_addr_b;
    for (int j = 1; j < LAT_B; j++) begin
      pv_b[j] <= pv_b[j-1];
      pa_b[j] <= pa_b[j-1];
    end
  end

  assign mem_rd_data_a = pv_a[LAT_A-1] ? memf(pa_a[LAT_A-1]) : 8'hEE;
  assign mem_rd_data_b = pv_b[LAT_B-1] ? memf(pa_b[LAT_B-1]) : 8'hEE;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  task automatic mon_step(input string nm, input int lat, input logic rd_en, input logic [15:0] maddr,
                          input logic qr, input logic rv, input logic [31:0] rd, input logic [15:0] rn,
                          input logic rc, inout mon_t m);
    resp_t e;
    if (rd_en) begin
      if (m.ai >= alist.size()) chk({nm, "_unexpected_rd_en"}, 32'(rd_en), 32'd0);
      else begin
        chk({nm, "_mem_addr"}, 32'(maddr), 32'(alist[m.ai]));
        if (mem_rdy) m.ai++;
      end
    end
    if (rv) begin
      chk({nm, "_req_ready_while_valid"}, 32'(qr), 32'd0);
      if (!m.vprev) begin
        if (m.ri >= rlist.size()) chk({nm, "_unexpected_rsp"}, 32'(rv), 32'd0);
        else begin
          e = rlist[m.ri];
          m.ri++;
          chk({nm, "_rsp_data"}, rd, e.d);
          chk({nm, "_rsp_next_addr"}, 32'(rn), 32'(e.nx));
          chk({nm, "_rsp_page_cross"}, 32'(rc), 32'(e.cr));
          chk({nm, "_latency"}, 32'(cyc - e.t0),
              32'((e.nb == 0) ? 1 : e.nb + 1 + e.stalls + lat));
        end
        m.hd = rd;
        m.hn = rn;
        m.hc = rc;
      end else begin
        chk({nm, "_hold_data"}, rd, m.hd);
        chk({nm, "_hold_next_addr"}, 32'(rn), 32'(m.hn));
        chk({nm, "_hold_page_cross"}, 32'(rc), 32'(m.hc));
      end
    end
    m.vprev = rv && !rsp_ready;
  endtask

  initial forever begin
    @(negedge clk);
    if (resetn) begin
      mon_step("a", LAT_A, mem_rd_en_a, mem_addr_a, req_ready_a, rsp_valid_a, rsp_data_a,
               rsp_next_addr_a, rsp_page_cross_a, ma);
      mon_step("b", LAT_B, mem_rd_en_b, mem_addr_b, req_ready_b, rsp_valid_b, rsp_data_b,
               rsp_next_addr_b, rsp_page_cross_b, mb);
    end else begin
      ma.vprev = 1'b0;
      mb.vprev = 1'b0;
    end
  end

  task automatic check_reset(input string nm);
    chk({nm, "_a_req_ready"}, 32'(req_ready_a), 32'd1);
    chk({nm, "_a_mem_rd_en"}, 32'(mem_rd_en_a), 32'd0);
    chk({nm, "_a_mem_addr"}, 32'(mem_addr_a), 32'd0);
    chk({nm, "_a_rsp_valid"}, 32'(rsp_valid_a), 32'd0);
    chk({nm, "_a_rsp_data"}, rsp_data_a, 32'd0);
    chk({nm, "_a_rsp_next_addr"}, 32'(rsp_next_addr_a), 32'd0);
    chk({nm, "_a_rsp_page_cross"}, 32'(rsp_page_cross_a), 32'd0);
    chk({nm, "_b_req_ready"}, 32'(req_ready_b), 32'd1);
    chk({nm, "_b_mem_rd_en"}, 32'(mem_rd_en_b), 32'd0);
    chk({nm, "_b_mem_addr"}, 32'(mem_addr_b), 32'd0);
    chk({nm, "_b_rsp_valid"}, 32'(rsp_valid_b), 32'd0);
    chk({nm, "_b_rsp_data"}, rsp_data_b, 32'd0);
    chk({nm, "_b_rsp_next_addr"}, 32'(rsp_next_addr_b), 32'd0);
    chk({nm, "_b_rsp_page_cross"}, 32'(rsp_page_cross_b), 32'd0);
  endtask

  // Called at posedge+1 with both instances idle; al holds expected addresses, first in bits [15:0].
  task automatic do_req(input logic [15:0] addr, input logic [2:0] len, input logic wrap, input int nb,
                        input logic [63:0] al, input logic [31:0] d, input logic [15:0] nx,
                        input logic cr, input int stalls);
    resp_t e;
    req_addr      = addr;
    req_len       = len;
    req_page_wrap = wrap;
    req_valid     = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int i = 0; i < nb; i++) alist.push_back(al[i*16 +: 16]);
    e = '{d: d, nx: nx, cr: cr, nb: nb, stalls: stalls, t0: cyc};
    rlist.push_back(e);
    if (stalls > 0) begin
      @(posedge clk);
      #1;
      mem_rdy = 1'b0;
      repeat (stalls) @(posedge clk);
      #1;
      mem_rdy = 1'b1;
    end
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!(ma.ri == rlist.size() && mb.ri == rlist.size() && req_ready_a && req_ready_b)) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 60) begin
        chk({nm, "_timeout"}, 32'(n), 32'd60);
        break;
      end
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    ma = '{ai: 0, ri: 0, vprev: 1'b0, hd: '0, hn: '0, hc: 1'b0};
    mb = '{ai: 0, ri: 0, vprev: 1'b0, hd: '0, hn: '0, hc: 1'b0};
    #12;
    check_reset("por");
    @(negedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;

    do_req(16'hFFFC, 3'd2, 1'b0, 2, {16'h0000, 16'h0000, 16'hFFFD, 16'hFFFC},
           32'h0000_1234, 16'hFFFE, 1'b0, 0);
    wait_done("reset_vector");

    do_req(16'hFFFF, 3'd3, 1'b0, 3, {16'h0000, 16'h0001, 16'h0000, 16'hFFFF},
           32'h0011_10F0, 16'h0002, 1'b1, 0);
    wait_done("wrap_cross");

    do_req(16'h0200, 3'd4, 1'b0, 4, {16'h0203, 16'h0202, 16'h0201, 16'h0200},
           32'h1110_1312, 16'h0204, 1'b0, 2);
    wait_done("stall");

    rsp_ready = 1'b0;
    do_req(16'h0140, 3'd3, 1'b0, 3, {16'h0000, 16'h0142, 16'h0141, 16'h0140},
           32'h0053_5051, 16'h0143, 1'b0, 0);
    n = 0;
    while (!(rsp_valid_a && rsp_valid_b) && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_both_valid", 32'(rsp_valid_a && rsp_valid_b), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_a_still_valid", 32'(rsp_valid_a), 32'd1);
    chk("bp_b_still_valid", 32'(rsp_valid_b), 32'd1);
    rsp_ready = 1'b1;
    wait_done("backpressure");

    do_req(16'h01FE, 3'd7, 1'b0, 4, {16'h0201, 16'h0200, 16'h01FF, 16'h01FE},
           32'h1312_0E0F, 16'h0202, 1'b1, 0);
    wait_done("clamp");

    do_req(16'h3456, 3'd0, 1'b0, 0, 64'd0, 32'd0, 16'h3456, 1'b0, 0);
    wait_done("zero_len");

    do_req(16'h0300, 3'd4, 1'b0, 4, {16'h0303, 16'h0302, 16'h0301, 16'h0300},
           32'h0, 16'h0304, 1'b0, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_reset("mid_reset");
    ma.ai = alist.size();
    ma.ri = rlist.size();
    mb.ai = alist.size();
    mb.ri = rlist.size();
    @(negedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;
    do_req(16'h0480, 3'd2, 1'b0, 2, {16'h0000, 16'h0000, 16'h0481, 16'h0480},
           32'h0000_9594, 16'h0482, 1'b0, 0);
    wait_done("after_reset");

`ifdef PAGE_WRAP_EN
    do_req(16'h12FF, 3'd2, 1'b1, 2, {16'h0000, 16'h0000, 16'h1200, 16'h12FF},
           32'h0000_021D, 16'h1201, 1'b0, 0);
`else
    do_req(16'h12FF, 3'd2, 1'b1, 2, {16'h0000, 16'h0000, 16'h1300, 16'h12FF},
           32'h0000_031D, 16'h1301, 1'b1, 0);
`endif
    wait_done("page_wrap");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_fetch_unit.md
Name: operand_fetch_unit

Overview:
Parametrised multi-byte memory read sequencer for the processor core. It generalises the fixed two-byte vector and absolute-operand fetches into one reusable block. It accepts a start address and byte count, then issues consecutive reads to a pipelined memory with a configurable read latency and a stall input. It assembles the returned bytes little-endian and hands the result back through a valid/ready handshake.

Parameters:
ADDR_W, 16, address width in bits (minimum 9)
DATA_W, 8, memory data width in bits
MAX_BYTES, 4, maximum bytes per request (minimum 2)
RD_LATENCY, 1, cycles from accepted read issue to valid mem_rd_data (minimum 1)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_addr  in  ADDR_W  first byte address
req_len  in  clog2(MAX_BYTES+1)  byte count
req_page_wrap  in  1  wrap within page (used only with PAGE_WRAP_EN)
mem_addr  out  ADDR_W  read address
mem_rd_en  out  1  read request
mem_rdy  in  1  memory accepts read this cycle
mem_rd_data  in  DATA_W  read data
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_data  out  MAX_BYTES*DATA_W  assembled operand; byte i in bits [i*DATA_W +: DATA_W]
rsp_next_addr  out  ADDR_W  address following last byte fetched
rsp_page_cross  out  1  a fetched byte lies outside the first byte's page

Behaviour:
- Clock and reset: one clock, clk. resetn is asynchronous and active-low.
- Reset values: all outputs 0 except req_ready=1. State=IDLE.
- A reset mid-operation aborts the request. In-flight returns are discarded and nothing is captured after reset release.
- State IDLE: req_ready=1. On req_valid&&req_ready, latch the request, clear rsp_data and go to BUSY.
  - req_len greater than MAX_BYTES is clamped to MAX_BYTES.
  - req_len=0 goes straight to DONE: rsp_data=0, rsp_next_addr=req_addr, rsp_page_cross=0.
- State BUSY, issue side:
  - mem_rd_en=1 while issued count < len.
  - mem_addr = start + issued count.
  - A read is accepted in a cycle where mem_rd_en&&mem_rdy. The issue counter advances only on acceptance. When mem_rdy=0, mem_addr is held stable.
- State BUSY, return side:
  - A read accepted in cycle t returns data valid during cycle t+RD_LATENCY, captured at the end of that cycle.
  - Returns are tracked with a RD_LATENCY-deep valid shift register, so back-to-back issues are fully pipelined.
  - Returns land in byte slots in issue order, using a capture counter.
- BUSY to DONE: after the final byte is captured.
- State DONE: rsp_valid=1 and rsp_data/rsp_next_addr/rsp_page_cross are held stable. On rsp_ready, go to IDLE; req_ready rises the next cycle. No new request is accepted in the same cycle as the handshake.
- Latency with mem_rdy held high: rsp_valid rises len+RD_LATENCY+1 cycles after the acceptance edge.
- Address arithmetic: modulo 2^ADDR_W, so 0xFFFF+1 = 0x0000. rsp_next_addr = start+len under the same rule.
- Page: address bits [ADDR_W-1:8]. rsp_page_cross=1 if any fetched address differs from the start in these bits.
- Byte slots at or above len read 0.

Optional Feature:
PAGE_WRAP_EN
- Defined: when the latched req_page_wrap=1, the increment affects only address bits [7:0], reproducing the original indirect-JMP behaviour (0x12FF, then 0x1200). rsp_next_addr follows the same rule, and rsp_page_cross is 0.
- Undefined, or req_page_wrap=0: normal full-width increment. The req_page_wrap port is present but ignored.

Test Plan:
- Reset vector fetch. Setup: RD_LATENCY=1, mem_rdy=1, mem[0xFFFC]=0x34, mem[0xFFFD]=0x12; request addr 0xFFFC, len 2. Response: reads of 0xFFFC then 0xFFFD; rsp_data[15:0]=0x1234; rsp_next_addr=0xFFFE; rsp_page_cross=0; rsp_valid 4 cycles after acceptance.
- Wrap and page cross. Request addr 0xFFFF, len 3. Response: addresses 0xFFFF, 0x0000, 0x0001; rsp_next_addr=0x0002; rsp_page_cross=1.
- Stall handling. Setup: RD_LATENCY=3, len 4 at 0x0200; mem_rdy low on the 2nd and 3rd issue cycles. Response: each address held while stalled; bytes in order; rsp_valid exactly 4+3+1+2 cycles after acceptance.
- Backpressure and clamping. rsp_ready low for 5 cycles: rsp_valid and rsp_data stable, req_ready=0. A later request with req_len=7 fetches only 4 bytes.
- Zero-length request. req_len=0: no mem_rd_en; rsp_valid 1 cycle after acceptance with rsp_data=0.
- Reset mid-fetch. Assert resetn low between the 2nd and 3rd issue of a 4-byte fetch: outputs return to reset values immediately. After release, a fresh 2-byte fetch returns correct data with no stale bytes.
- PAGE_WRAP_EN defined. Request addr 0x12FF, len 2, req_page_wrap=1. Response: reads 0x12FF then 0x1200; rsp_next_addr=0x1201; rsp_page_cross=0.
